pipeline_ctrl: RTL and testbench

Central sequencer for the five-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register. It turns cache handshakes, MEM-stage control-flow resolution, load-use hazards and halt into per-latch enable/flush strobes, a PC select and a data-request mask. It sits beside the datapath, reading MEM-stage fields from the EX/MEM latch outputs and register fields from IF/ID and ID/EX.

---
 rtl/cpu_types_pkg.sv | 37 +++
 rtl/pctrl_if.sv | 48 ++++
 rtl/hazard_detect.sv | 19 +
 rtl/pipeline_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline control slice.
//   regbits_t     : register-file index (5 bits)
//   pctrl_state_t : sequencer states
//   pctrl_ctl_t   : bundle of per-latch enables/flushes, PC select and data-request mask
package cpu_types_pkg;

  localparam int unsigned REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [2:0] {
    RUN,
    DWAIT,
    DDONE,
    REDIRECT,
    HALT
  } pctrl_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic pc_sel;
    logic dmem_mask;
  } pctrl_ctl_t;

  // Every latch and the PC advance, no flushes, PC+4, cache requests pass through.
  localparam pctrl_ctl_t CTL_ADVANCE = pctrl_ctl_t'(10'b11111_00000);
  // Everything held.
  localparam pctrl_ctl_t CTL_FROZEN  = pctrl_ctl_t'(10'b00000_00000);

endpackage

// File: rtl/pctrl_if.sv
// Signal bundle between the pipeline sequencer and the datapath.
//   ctrl     : sequencer view (hazard/handshake inputs, strobe outputs)
//   datapath : datapath view (drives handshakes and stage fields, consumes strobes)
interface pctrl_if
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) ();

  logic             ihit;
  logic             dhit;
  logic             mem_dren;
  logic             mem_dwen;
  logic             mem_redirect;
  logic             mem_halt;
  logic             ex_dload;
  regbits_t         ex_rt;
  regbits_t         id_rs;
  regbits_t         id_rt;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             pc_sel;
  logic             dmem_mask;
  logic             halt;
  logic [CNT_W-1:0] stall_cnt;

  modport ctrl (
    input  ihit, dhit, mem_dren, mem_dwen, mem_redirect, mem_halt,
    input  ex_dload, ex_rt, id_rs, id_rt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, exmem_flush, pc_sel, dmem_mask, halt, stall_cnt
  );

  modport datapath (
    output ihit, dhit, mem_dren, mem_dwen, mem_redirect, mem_halt,
    output ex_dload, ex_rt, id_rs, id_rt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_flush, exmem_flush, pc_sel, dmem_mask, halt, stall_cnt
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard compare.
//   ex_dload  : ID/EX holds a load
//   ex_rt     : destination register of that load
//   id_rs/rt  : IF/ID source registers
//   load_use  : the instruction in ID needs the load result before it exists
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     ex_dload,
  input  regbits_t ex_rt,
  input  regbits_t id_rs,
  input  regbits_t id_rt,
  output logic     load_use
);

  // $zero is never a real dependency.
  assign load_use = ex_dload && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the IF/ID, ID/EX, EX/MEM, MEM/WB latches and the PC.
//   CLK, nRST               : clock (rising edge), asynchronous active-low reset
//   ihit, dhit              : instruction / data cache completion
//   mem_dren, mem_dwen      : MEM-stage read / write request
//   mem_redirect, mem_halt  : MEM-stage control-flow change / halt
//   ex_dload, ex_rt         : load in ID/EX and its destination
//   id_rs, id_rt            : IF/ID source registers
//   *_en, *_flush           : latch enables and bubble-insert strobes (flush dominates)
//   pc_sel                  : 0 = PC+4, 1 = MEM-stage redirect target
//   dmem_mask               : blocks data requests reaching the cache
//   halt                    : sticky, registered halt
//   stall_cnt               : saturating count of cycles with pc_en=0 outside HALT
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dren,
  input  logic             mem_dwen,
  input  logic             mem_redirect,
  input  logic             mem_halt,
  input  logic             ex_dload,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pc_sel,
  output logic             dmem_mask,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt
);

  pctrl_if #(.CNT_W(CNT_W)) pif ();

  assign pif.ihit         = ihit;
  assign pif.dhit         = dhit;
  assign pif.mem_dren     = mem_dren;
  assign pif.mem_dwen     = mem_dwen;
  assign pif.mem_redirect = mem_redirect;
  assign pif.mem_halt     = mem_halt;
  assign pif.ex_dload     = ex_dload;
  assign pif.ex_rt        = ex_rt;
  assign pif.id_rs        = id_rs;
  assign pif.id_rt        = id_rt;

  pctrl_state_t     state_q, state_d;
  pctrl_ctl_t       ctl;
  logic             halt_q;
  logic [CNT_W-1:0] cnt_q;
  logic             load_use;
  logic             mem_pending;
  logic             run_rules;
  logic             chk_mem;

  hazard_detect u_hazard (
    .ex_dload (pif.ex_dload),
    .ex_rt    (pif.ex_rt),
    .id_rs    (pif.id_rs),
    .id_rt    (pif.id_rt),
    .load_use (load_use)
  );

  // A request that already hit this cycle completes in place and needs no wait.
  assign mem_pending = (pif.mem_dren || pif.mem_dwen) && !pif.dhit;

  always_comb begin
    ctl       = CTL_ADVANCE;
    state_d   = state_q;
    run_rules = 1'b0;
    chk_mem   = 1'b0;

    case (state_q)
      RUN: begin
        run_rules = 1'b1;
        chk_mem   = 1'b1;
      end
      DWAIT: begin
        ctl = CTL_FROZEN;
        if (pif.dhit) begin
          if (pif.ihit) begin
            // Data returned with fetch ready: resume immediately under normal rules.
            run_rules = 1'b1;
          end else begin
            // Retire the finished access into MEM/WB, hold the front end for the fetch.
            ctl.memwb_en    = 1'b1;
            ctl.exmem_flush = 1'b1;
            state_d         = DDONE;
          end
        end
      end
      DDONE: begin
        if (pif.ihit) begin
          ctl     = CTL_ADVANCE;
          state_d = RUN;
        end else begin
          ctl = CTL_FROZEN;
        end
        // The access has already completed; keep it from being replayed.
        ctl.dmem_mask = 1'b1;
      end
      REDIRECT: begin
        ctl.ifid_flush = 1'b1;
        ctl.pc_en      = pif.ihit;
        if (pif.ihit) begin
          state_d = RUN;
        end
      end
      HALT: begin
        ctl           = CTL_FROZEN;
        ctl.dmem_mask = 1'b1;
      end
      default: begin
        ctl     = CTL_FROZEN;
        state_d = RUN;
      end
    endcase

    if (run_rules) begin
      if (pif.mem_halt) begin
        ctl             = CTL_FROZEN;
        ctl.memwb_en    = 1'b1;
        ctl.exmem_flush = 1'b1;
        state_d         = HALT;
      end else if (chk_mem && mem_pending) begin
        ctl     = CTL_FROZEN;
        state_d = DWAIT;
      end else if (pif.mem_redirect) begin
        ctl             = CTL_ADVANCE;
        ctl.pc_sel      = 1'b1;
        ctl.ifid_flush  = 1'b1;
        ctl.idex_flush  = 1'b1;
        ctl.exmem_flush = 1'b1;
        state_d         = REDIRECT;
      end else if (load_use) begin
        // Hold PC and IF/ID one cycle; a bubble enters EX behind the load.
        ctl            = CTL_ADVANCE;
        ctl.pc_en      = 1'b0;
        ctl.ifid_en    = 1'b0;
        ctl.idex_flush = 1'b1;
        state_d        = RUN;
      end else if (!pif.ihit) begin
        ctl            = CTL_ADVANCE;
        ctl.pc_en      = 1'b0;
        ctl.ifid_flush = 1'b1;
        state_d        = RUN;
      end else begin
        ctl     = CTL_ADVANCE;
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      halt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == HALT) begin
        halt_q <= 1'b1;
      end
      if (!ctl.pc_en && (state_q != HALT) && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign pif.pc_en       = ctl.pc_en;
  assign pif.ifid_en     = ctl.ifid_en;
  assign pif.idex_en     = ctl.idex_en;
  assign pif.exmem_en    = ctl.exmem_en;
  assign pif.memwb_en    = ctl.memwb_en;
  assign pif.ifid_flush  = ctl.ifid_flush;
  assign pif.idex_flush  = ctl.idex_flush;
  assign pif.exmem_flush = ctl.exmem_flush;
  assign pif.pc_sel      = ctl.pc_sel;
  assign pif.dmem_mask   = ctl.dmem_mask;
  assign pif.halt        = halt_q;
  assign pif.stall_cnt   = cnt_q;

  assign pc_en       = pif.pc_en;
  assign ifid_en     = pif.ifid_en;
  assign idex_en     = pif.idex_en;
  assign exmem_en    = pif.exmem_en;
  assign memwb_en    = pif.memwb_en;
  assign ifid_flush  = pif.ifid_flush;
  assign idex_flush  = pif.idex_flush;
  assign exmem_flush = pif.exmem_flush;
  assign pc_sel      = pif.pc_sel;
  assign dmem_mask   = pif.dmem_mask;
  assign halt        = pif.halt;
  assign stall_cnt   = pif.stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: stimulus pushes expectations from a behavioural model,
// a negedge monitor pops and compares.
module tb_pipeline_ctrl;

  localparam int CW = 16;

  // Bit positions of the control word {pc_en .. dmem_mask}.
  localparam int B_PC   = 9;
  localparam int B_IFE  = 8;
  localparam int B_MWB  = 5;
  localparam int B_IFF  = 4;
  localparam int B_IDF  = 3;
  localparam int B_EXF  = 2;
  localparam int B_SEL  = 1;
  localparam int B_MASK = 0;
  localparam logic [9:0] ADV = 10'b11111_00000;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic ihit, dhit, mem_dren, mem_dwen, mem_redirect, mem_halt, ex_dload;
  logic [4:0] ex_rt, id_rs, id_rt;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, pc_sel, dmem_mask, halt;
  logic [CW-1:0] stall_cnt;

  always #5 CLK = ~CLK;

  pipeline_ctrl #(.CNT_W(CW)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .ihit         (ihit),
    .dhit         (dhit),
    .mem_dren     (mem_dren),
    .mem_dwen     (mem_dwen),
    .mem_redirect (mem_redirect),
    .mem_halt     (mem_halt),
    .ex_dload     (ex_dload),
    .ex_rt        (ex_rt),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_en      (idex_en),
    .exmem_en     (exmem_en),
    .memwb_en     (memwb_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .pc_sel       (pc_sel),
    .dmem_mask    (dmem_mask),
    .halt         (halt),
    .stall_cnt    (stall_cnt)
  );

  typedef struct packed {
    logic [9:0]    ctl;
    logic          halt;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: which wait the pipeline is in, plus running stall total.
  bit m_wait_data, m_data_done, m_redirecting, m_halted;
  int m_stalls;

  // Normal-flow priority list; nxt: 0 stay, 1 wait data, 2 redirect, 3 halt.
  function automatic logic [9:0] normal_rules(input bit chk_mem, output int nxt);
    logic [9:0] c;
    bit dep;
    nxt = 0;
    dep = ex_dload && (ex_rt != 5'd0) && (ex_rt == id_rs || ex_rt == id_rt);
    if (mem_halt) begin
      c = '0; c[B_MWB] = 1'b1; c[B_EXF] = 1'b1; nxt = 3;
    end else if (chk_mem && (mem_dren || mem_dwen) && !dhit) begin
      c = '0; nxt = 1;
    end else if (mem_redirect) begin
      c = ADV; c[B_SEL] = 1'b1; c[B_IFF] = 1'b1; c[B_IDF] = 1'b1; c[B_EXF] = 1'b1; nxt = 2;
    end else if (dep) begin
      c = ADV; c[B_PC] = 1'b0; c[B_IFE] = 1'b0; c[B_IDF] = 1'b1;
    end else if (!ihit) begin
      c = ADV; c[B_PC] = 1'b0; c[B_IFF] = 1'b1;
    end else begin
      c = ADV;
    end
    return c;
  endfunction

  task automatic model_cycle(input bit rst_now, output exp_t e);
    logic [9:0] c;
    int nxt;
    nxt = 0;
    if (rst_now) begin
      m_wait_data = 0; m_data_done = 0; m_redirecting = 0; m_halted = 0; m_stalls = 0;
    end
    e.halt = m_halted;
    e.cnt  = CW'(m_stalls);
    if (m_halted) begin
      c = '0; c[B_MASK] = 1'b1;
    end else if (m_redirecting) begin
      c = ADV; c[B_PC] = ihit; c[B_IFF] = 1'b1;
      if (ihit) m_redirecting = 0;
    end else if (m_data_done) begin
      c = ihit ? ADV : 10'd0; c[B_MASK] = 1'b1;
      if (ihit) m_data_done = 0;
    end else if (m_wait_data) begin
      if (!dhit) begin
        c = '0;
      end else if (!ihit) begin
        c = '0; c[B_MWB] = 1'b1; c[B_EXF] = 1'b1;
        m_wait_data = 0; m_data_done = 1;
      end else begin
        m_wait_data = 0;
        c = normal_rules(1'b0, nxt);
      end
    end else begin
      c = normal_rules(1'b1, nxt);
    end
    if (nxt == 1) m_wait_data = 1;
    if (nxt == 2) m_redirecting = 1;
    if (nxt == 3) m_halted = 1;
    if (!c[B_PC] && !e.halt && m_stalls < (2 ** CW) - 1) m_stalls++;
    if (rst_now) begin
      // Reset still held at the coming edge: nothing advances.
      m_wait_data = 0; m_data_done = 0; m_redirecting = 0; m_halted = 0; m_stalls = 0;
    end
    e.ctl = c;
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b0; mem_dren = 1'b0; mem_dwen = 1'b0;
    mem_redirect = 1'b0; mem_halt = 1'b0; ex_dload = 1'b0;
    ex_rt = 5'd0; id_rs = 5'd1; id_rt = 5'd2;
  endtask

  // Called at posedge+1: apply current inputs for one cycle.
  task automatic step(input bit rst_now);
    exp_t e;
    nRST = !rst_now;
    model_cycle(rst_now, e);
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  // Monitor: compare away from the active edge.
  always @(negedge CLK) begin
    exp_t e;
    logic [9:0] got;
    if (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      got = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, exmem_flush, pc_sel, dmem_mask};
      checks++;
      if (got !== e.ctl) begin
        errors++;
        $display("FAIL ctl t=%0t got=%b want=%b", $time, got, e.ctl);
      end
      checks++;
      if (halt !== e.halt) begin
        errors++;
        $display("FAIL halt t=%0t got=%b want=%b", $time, halt, e.halt);
      end
      checks++;
      if (stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL stall_cnt t=%0t got=%0d want=%0d", $time, stall_cnt, e.cnt);
      end
    end
  end

  initial begin
    int halted_cycles;
    idle();
    @(posedge CLK);
    #1;
    step(1'b1);

    // Load-use stall, then clean advance.
    ex_dload = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; step(1'b0);
    idle(); step(1'b0); step(1'b0);

    // Load to $zero is no dependency.
    ex_dload = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; step(1'b0);
    idle(); step(1'b0);

    // Data miss, late fetch.
    mem_dren = 1'b1; dhit = 1'b0;
    repeat (3) step(1'b0);
    dhit = 1'b1; ihit = 1'b0; step(1'b0);
    dhit = 1'b0; repeat (2) step(1'b0);
    ihit = 1'b1; step(1'b0);
    idle(); step(1'b0);

    // Redirect with fetch misses.
    mem_redirect = 1'b1; ihit = 1'b0; step(1'b0);
    mem_redirect = 1'b0; step(1'b0);
    ihit = 1'b1; step(1'b0);
    idle(); step(1'b0);

    // Reset in the middle of a data wait.
    mem_dwen = 1'b1; dhit = 1'b0; step(1'b0); step(1'b0);
    step(1'b1);
    idle(); step(1'b0);

    // Halt beats redirect, then stays frozen.
    mem_halt = 1'b1; mem_redirect = 1'b1; step(1'b0);
    idle(); mem_dren = 1'b1; ihit = 1'b0; repeat (3) step(1'b0);
    idle(); step(1'b1);
    step(1'b0);

    // Random traffic.
    halted_cycles = 0;
    for (int i = 0; i < 1500; i++) begin
      ihit         = ($urandom_range(0, 3) != 0);
      dhit         = 1'($urandom_range(0, 1));
      mem_dren     = ($urandom_range(0, 3) == 0);
      mem_dwen     = ($urandom_range(0, 7) == 0);
      mem_redirect = ($urandom_range(0, 7) == 0);
      mem_halt     = ($urandom_range(0, 49) == 0);
      ex_dload     = ($urandom_range(0, 2) == 0);
      ex_rt        = 5'($urandom_range(0, 3));
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      halted_cycles = m_halted ? halted_cycles + 1 : 0;
      if (halted_cycles > 4 || $urandom_range(0, 59) == 0) begin
        step(1'b1);
      end else begin
        step(1'b0);
      end
    end

    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending want=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
